// File: rtl/pc_sequencer.sv
// Purpose : PC-source / PC-write sequencer for the multicycle datapath, with EPC capture and exception-vector fetch.
// Latency : 3 cycles FETCH->FETCH for branch/jump/jr/rte; 3+N for EXEC; exceptions reach FETCH >= 4 cycles after the event.
// Backpr. : stalls in EXEC until exec_done and in EXC_WAIT until exc_ready or the EXC_WAIT_MAX timeout.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   opcode, funct         IR[31:26] / IR[5:0], stable from DECODE onward
//   zero, gt              ALU flags, used combinationally in BRANCH
//   overflow, div_zero    exception sources, sampled in EXEC only
//   exec_done             main control finished the instruction body
//   exc_ready             exception vector valid (honoured in EXC_WAIT only)
//   PC_src                000 ULA_out, 001 ALUOut, 010 jump, 011 exc vector, 100 EPC
//   PC_write, EPC_write   one-cycle load strobes
//   exc_req, exc_cause    vector read request and latched cause (00 inv, 01 ovf, 10 div0)
//   exec_start            one-cycle pulse in the first EXEC cycle
//
// Build option: define PC_SEQ_EXC_EN to include exception states, cause register,
// timeout counter and RTE. Without it, invalid opcodes and RTE return to FETCH and
// overflow/div_zero/exc_ready are ignored.
module pc_sequencer #(
    parameter int EXC_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       gt,
    input  logic       overflow,
    input  logic       div_zero,
    input  logic       exec_done,
    input  logic       exc_ready,
    output logic [2:0] PC_src,
    output logic       PC_write,
    output logic       EPC_write,
    output logic       exc_req,
    output logic [1:0] exc_cause,
    output logic       exec_start
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_BRANCH   = 4'd2,
        S_JUMP     = 4'd3,
        S_JR       = 4'd4,
        S_RTE      = 4'd5,
        S_EXEC     = 4'd6,
        S_EXC_EPC  = 4'd7,
        S_EXC_WAIT = 4'd8,
        S_EXC_LOAD = 4'd9
    } state_t;

    localparam logic [2:0] SRC_ULA  = 3'b000;
    localparam logic [2:0] SRC_ALU  = 3'b001;
    localparam logic [2:0] SRC_JMP  = 3'b010;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLE   = 6'h06;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_RTE   = 6'h13;

    state_t state_q, state_d;
    logic   exec_first_q, exec_first_d;

    logic is_branch, is_jump, is_jr, is_rte, is_legal, branch_taken;

    always_comb begin
        is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                    (opcode == OP_BLE) || (opcode == OP_BGT);
        is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
        is_jr     = (opcode == OP_RTYPE) && (funct == FN_JR);
        is_rte    = (opcode == OP_RTYPE) && (funct == FN_RTE);
        is_legal  = (opcode == OP_RTYPE) || (opcode == 6'h08) || (opcode == 6'h09) ||
                    (opcode == 6'h0F) || ((opcode >= 6'h20) && (opcode <= 6'h2B));
    end

    // Branch condition is evaluated on the live flags; opcode is stable here.
    always_comb begin
        branch_taken = 1'b0;
        case (opcode)
            OP_BEQ:  branch_taken = zero;
            OP_BNE:  branch_taken = !zero;
            OP_BLE:  branch_taken = !gt;
            OP_BGT:  branch_taken = gt;
            default: branch_taken = 1'b0;
        endcase
    end

`ifdef PC_SEQ_EXC_EN
    localparam logic [2:0] SRC_VEC   = 3'b011;
    localparam logic [2:0] SRC_EPC   = 3'b100;
    localparam logic [1:0] CAUSE_INV = 2'b00;
    localparam logic [1:0] CAUSE_OVF = 2'b01;
    localparam logic [1:0] CAUSE_DIV = 2'b10;
    // Counter holds cycles already spent in EXC_WAIT, so the last allowed
    // cycle is the one where it reads EXC_WAIT_MAX-1.
    localparam logic [3:0] WAIT_LAST = 4'(EXC_WAIT_MAX - 1);

    logic [1:0] cause_q, cause_d;
    logic [3:0] cnt_q, cnt_d;
`else
    logic unused_exc_inputs;
    assign unused_exc_inputs = &{1'b0, overflow, div_zero, exc_ready, (EXC_WAIT_MAX != 0)};
`endif

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        exec_first_d = 1'b0;
`ifdef PC_SEQ_EXC_EN
        cause_d      = cause_q;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (is_branch) begin
                    state_d = S_BRANCH;
                end else if (is_jump) begin
                    state_d = S_JUMP;
                end else if (is_jr) begin
                    state_d = S_JR;
                end else if (is_rte) begin
`ifdef PC_SEQ_EXC_EN
                    state_d = S_RTE;
`else
                    state_d = S_FETCH;
`endif
                end else if (is_legal) begin
                    state_d      = S_EXEC;
                    exec_first_d = 1'b1;
                end else begin
`ifdef PC_SEQ_EXC_EN
                    state_d = S_EXC_EPC;
                    cause_d = CAUSE_INV;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_BRANCH, S_JUMP, S_JR, S_RTE: state_d = S_FETCH;
            S_EXEC: begin
`ifdef PC_SEQ_EXC_EN
                if (overflow) begin
                    state_d = S_EXC_EPC;
                    cause_d = CAUSE_OVF;
                end else if (div_zero) begin
                    state_d = S_EXC_EPC;
                    cause_d = CAUSE_DIV;
                end else
`endif
                if (exec_done) begin
                    state_d = S_FETCH;
                end
            end
`ifdef PC_SEQ_EXC_EN
            S_EXC_EPC: begin
                state_d = S_EXC_WAIT;
                cnt_d   = 4'd0;
            end
            S_EXC_WAIT: begin
                if (exc_ready || (cnt_q == WAIT_LAST)) begin
                    state_d = S_EXC_LOAD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_EXC_LOAD: state_d = S_FETCH;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Moore outputs, forced idle while reset is asserted so no partial
    // PC/EPC load can escape during an asynchronous reset.
    always_comb begin
        PC_src     = SRC_ULA;
        PC_write   = 1'b0;
        EPC_write  = 1'b0;
        exc_req    = 1'b0;
        exec_start = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH:  PC_write = 1'b1;
                S_BRANCH: begin
                    PC_src   = SRC_ALU;
                    PC_write = branch_taken;
                end
                S_JUMP: begin
                    PC_src   = SRC_JMP;
                    PC_write = 1'b1;
                end
                S_JR:     PC_write = 1'b1;
                S_EXEC:   exec_start = exec_first_q;
`ifdef PC_SEQ_EXC_EN
                S_RTE: begin
                    PC_src   = SRC_EPC;
                    PC_write = 1'b1;
                end
                S_EXC_EPC:  EPC_write = 1'b1;
                S_EXC_WAIT: exc_req = 1'b1;
                S_EXC_LOAD: begin
                    PC_src   = SRC_VEC;
                    PC_write = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef PC_SEQ_EXC_EN
    assign exc_cause = cause_q;
`else
    assign exc_cause = 2'b00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            exec_first_q <= exec_first_d;
        end
    end

`ifdef PC_SEQ_EXC_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_q <= 2'b00;
            cnt_q   <= 4'd0;
        end else begin
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose : directed self-checking bench for pc_sequencer (both exception-enabled and disabled builds).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpr. : exec_done / exc_ready are driven explicitly by the stimulus.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       gt = 1'b0;
    logic       overflow = 1'b0;
    logic       div_zero = 1'b0;
    logic       exec_done = 1'b0;
    logic       exc_ready = 1'b0;
    logic [2:0] PC_src;
    logic       PC_write;
    logic       EPC_write;
    logic       exc_req;
    logic [1:0] exc_cause;
    logic       exec_start;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] cause_exp = 2'b00;

    always #5 clk = ~clk;

    pc_sequencer #(.EXC_WAIT_MAX(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .gt         (gt),
        .overflow   (overflow),
        .div_zero   (div_zero),
        .exec_done  (exec_done),
        .exc_ready  (exc_ready),
        .PC_src     (PC_src),
        .PC_write   (PC_write),
        .EPC_write  (EPC_write),
        .exc_req    (exc_req),
        .exc_cause  (exc_cause),
        .exec_start (exec_start)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Sample all strobes on the falling edge of the current cycle.
    task automatic chk_out(input string tag, input logic [2:0] src, input logic pcw,
                           input logic epcw, input logic req);
        @(negedge clk);
        chk({tag, ".src"},   32'(PC_src),    32'(src));
        chk({tag, ".pcw"},   32'(PC_write),  32'(pcw));
        chk({tag, ".epcw"},  32'(EPC_write), 32'(epcw));
        chk({tag, ".req"},   32'(exc_req),   32'(req));
        chk({tag, ".cause"}, 32'(exc_cause), 32'(cause_exp));
    endtask

    // FETCH -> DECODE -> third cycle; ends positioned in the following FETCH.
    task automatic run_short(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic g,
                             input logic [2:0] exp_src, input logic exp_pcw);
        opcode = op; funct = fn; zero = z; gt = g;
        chk_out({tag, ".fetch"}, 3'b000, 1'b1, 1'b0, 1'b0);
        next_cyc();
        chk_out({tag, ".decode"}, 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        chk_out({tag, ".c3"}, exp_src, exp_pcw, 1'b0, 1'b0);
        next_cyc();
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        chk_out("rst", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("rst.start", 32'(exec_start), 32'd0);
        next_cyc();
        reset = 1'b0;

        // R-type add, exec_done in the 2nd EXEC cycle: PC_write in cycles 1 and 5.
        opcode = 6'h00; funct = 6'h20;
        chk_out("add.c1", 3'b000, 1'b1, 1'b0, 1'b0);
        next_cyc();
        chk_out("add.c2", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("add.c2.start", 32'(exec_start), 32'd0);
        next_cyc();
        chk_out("add.c3", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("add.c3.start", 32'(exec_start), 32'd1);
        next_cyc();
        exec_done = 1'b1;
        chk_out("add.c4", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("add.c4.start", 32'(exec_start), 32'd0);
        next_cyc();
        exec_done = 1'b0;

        // Branches
        run_short("beq",   6'h04, 6'h00, 1'b1, 1'b0, 3'b001, 1'b1);
        run_short("bne",   6'h05, 6'h00, 1'b1, 1'b0, 3'b001, 1'b0);
        run_short("ble",   6'h06, 6'h00, 1'b0, 1'b0, 3'b001, 1'b1);
        run_short("bgt_n", 6'h07, 6'h00, 1'b0, 1'b0, 3'b001, 1'b0);
        run_short("bgt_t", 6'h07, 6'h00, 1'b0, 1'b1, 3'b001, 1'b1);

        // Jumps
        run_short("j",   6'h02, 6'h00, 1'b0, 1'b0, 3'b010, 1'b1);
        run_short("jal", 6'h03, 6'h00, 1'b0, 1'b0, 3'b010, 1'b1);
        run_short("jr",  6'h00, 6'h08, 1'b0, 1'b0, 3'b000, 1'b1);

`ifdef PC_SEQ_EXC_EN
        run_short("rte", 6'h00, 6'h13, 1'b0, 1'b0, 3'b100, 1'b1);

        // Invalid opcode: EPC capture, wait, vector load on exc_ready.
        opcode = 6'h3F; funct = 6'h00;
        chk_out("inv.fetch", 3'b000, 1'b1, 1'b0, 1'b0);
        next_cyc();
        chk_out("inv.decode", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        chk_out("inv.epc", 3'b000, 1'b0, 1'b1, 1'b0);
        next_cyc();
        chk_out("inv.w1", 3'b000, 1'b0, 1'b0, 1'b1);
        next_cyc();
        chk_out("inv.w2", 3'b000, 1'b0, 1'b0, 1'b1);
        next_cyc();
        exc_ready = 1'b1;
        chk_out("inv.w3", 3'b000, 1'b0, 1'b0, 1'b1);
        next_cyc();
        exc_ready = 1'b0;
        chk_out("inv.load", 3'b011, 1'b1, 1'b0, 1'b0);
        next_cyc();

        // Overflow + div_zero + exec_done together: overflow wins; timeout after 15 waits.
        opcode = 6'h00; funct = 6'h20;
        chk_out("ovf.fetch", 3'b000, 1'b1, 1'b0, 1'b0);
        next_cyc();
        chk_out("ovf.decode", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        overflow = 1'b1; div_zero = 1'b1; exec_done = 1'b1; exc_ready = 1'b1;
        chk_out("ovf.exec", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        overflow = 1'b0; div_zero = 1'b0; exec_done = 1'b0; exc_ready = 1'b0;
        cause_exp = 2'b01;
        chk_out("ovf.epc", 3'b000, 1'b0, 1'b1, 1'b0);
        next_cyc();
        for (int i = 0; i < 15; i++) begin
            chk_out($sformatf("ovf.w%0d", i + 1), 3'b000, 1'b0, 1'b0, 1'b1);
            next_cyc();
        end
        chk_out("ovf.load", 3'b011, 1'b1, 1'b0, 1'b0);
        next_cyc();

        // div_zero alone, then reset asserted during EXC_WAIT.
        opcode = 6'h2B; funct = 6'h00;
        chk_out("div.fetch", 3'b000, 1'b1, 1'b0, 1'b0);
        next_cyc();
        chk_out("div.decode", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        div_zero = 1'b1;
        chk_out("div.exec", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        div_zero = 1'b0;
        cause_exp = 2'b10;
        chk_out("div.epc", 3'b000, 1'b0, 1'b1, 1'b0);
        next_cyc();
        chk_out("div.w1", 3'b000, 1'b0, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        cause_exp = 2'b00;
        chk("arst.req",   32'(exc_req),   32'd0);
        chk("arst.pcw",   32'(PC_write),  32'd0);
        chk("arst.epcw",  32'(EPC_write), 32'd0);
        chk("arst.cause", 32'(exc_cause), 32'd0);
`else
        // RTE and invalid opcodes fall straight back to FETCH.
        opcode = 6'h00; funct = 6'h13;
        chk_out("rte.fetch", 3'b000, 1'b1, 1'b0, 1'b0);
        next_cyc();
        chk_out("rte.decode", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        chk_out("rte.back", 3'b000, 1'b1, 1'b0, 1'b0);
        opcode = 6'h3F; funct = 6'h00;
        next_cyc();
        chk_out("inv.decode", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        chk_out("inv.back", 3'b000, 1'b1, 1'b0, 1'b0);
        opcode = 6'h02;
        next_cyc();
        chk_out("j2.decode", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        chk_out("j2.jump", 3'b010, 1'b1, 1'b0, 1'b0);
        next_cyc();

        // Exception sources ignored: exec_done alone decides.
        opcode = 6'h00; funct = 6'h20;
        chk_out("ovf.fetch", 3'b000, 1'b1, 1'b0, 1'b0);
        next_cyc();
        chk_out("ovf.decode", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        overflow = 1'b1; div_zero = 1'b1;
        chk_out("ovf.hold", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        exec_done = 1'b1;
        chk_out("ovf.exec", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        overflow = 1'b0; div_zero = 1'b0; exec_done = 1'b0;

        // Reset asserted in the first EXEC cycle.
        opcode = 6'h2B;
        chk_out("div.fetch", 3'b000, 1'b1, 1'b0, 1'b0);
        next_cyc();
        chk_out("div.decode", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        chk_out("div.exec", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("div.exec.start", 32'(exec_start), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst.start", 32'(exec_start), 32'd0);
        chk("arst.pcw",   32'(PC_write),  32'd0);
`endif
        next_cyc();
        reset = 1'b0;
        chk_out("post.fetch", 3'b000, 1'b1, 1'b0, 1'b0);
        next_cyc();
        chk_out("post.decode", 3'b000, 1'b0, 1'b0, 1'b0);
        next_cyc();
        chk_out("post.exec", 3'b000, 1'b0, 1'b0, 1'b0);
        chk("post.exec.start", 32'(exec_start), 32'd1);
        exec_done = 1'b1;
        next_cyc();
        exec_done = 1'b0;
        chk_out("post.refetch", 3'b000, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Control-side sequencer that drives the PC source select and PC write enables of the multicycle datapath. It decodes the current instruction class, branch flags and exception sources, and walks a per-instruction FSM that issues the 3-bit `PC_src` code and `PC_write` strobe consumed by the PC input mux. It also sequences EPC capture and exception-vector fetch.

## Interface
- Parameters:
- `EXC_WAIT_MAX`, default 15: cycles to wait for `exc_ready` before forcing the vector load.
- Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  6  IR[31:26], stable from DECODE onward.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `gt`  in  1  ALU greater-than flag.
- `overflow`  in  1  ALU overflow, sampled only in EXEC.
- `div_zero`  in  1  divider divide-by-zero, sampled only in EXEC.
- `exec_done`  in  1  main control reports the instruction body has finished.
- `exc_ready`  in  1  exception vector byte is valid on the datapath.
- `PC_src`  out  3  000 ULA_out, 001 ALUOut, 010 jump, 011 exception vector, 100 EPC.
- `PC_write`  out  1  PC load strobe, one cycle.
- `EPC_write`  out  1  EPC load strobe, one cycle.
- `exc_req`  out  1  request for a vector read.
- `exc_cause`  out  2  00 invalid opcode, 01 overflow, 10 divide by zero.
- `exec_start`  out  1  one-cycle pulse handing the instruction body to main control.

## Operation
- States: FETCH, DECODE, BRANCH, JUMP, JR, RTE, EXEC, EXC_EPC, EXC_WAIT, EXC_LOAD.
- FETCH: `PC_src`=000, `PC_write`=1 (PC+4). Next state is DECODE.
- DECODE: outputs are idle. Classification:
  - beq 0x04, bne 0x05, ble 0x06, bgt 0x07 go to BRANCH.
  - j 0x02, jal 0x03 go to JUMP.
  - R-type with funct 0x08 goes to JR.
  - R-type with funct 0x13 goes to RTE.
  - Other legal opcodes (R-type 0x00, 0x08, 0x09, 0x0F, 0x20–0x2B) go to EXEC with `exec_start`=1.
  - Anything else goes to EXC_EPC with cause 00.
- BRANCH: `PC_src`=001. `PC_write` is set when the branch condition holds:
  - beq: `zero`.
  - bne: `!zero`.
  - ble: `!gt`.
  - bgt: `gt`.
  - Next state is FETCH.
- JUMP: `PC_src`=010, `PC_write`=1. Next state is FETCH. The jal link write is owned by main control.
- JR: `PC_src`=000, `PC_write`=1. Next state is FETCH.
- RTE: `PC_src`=100, `PC_write`=1. Next state is FETCH.
- EXEC: hold until an event.
  - `overflow` goes to EXC_EPC with cause 01.
  - Otherwise `div_zero` goes to EXC_EPC with cause 10.
  - Otherwise `exec_done` goes to FETCH.
  - Overflow has priority over div_zero. Either exception has priority over `exec_done` in the same cycle.
- EXC_EPC: `EPC_write`=1. Next state is EXC_WAIT.
- EXC_WAIT: `exc_req`=1 and `exc_cause` is held.
  - Go to EXC_LOAD on `exc_ready`, or after `EXC_WAIT_MAX` cycles in this state.
  - The timeout counter is 4 bits and is cleared on entry.
- EXC_LOAD: `PC_src`=011, `PC_write`=1. `exc_cause` is retained until the next exception. Next state is FETCH.
- `PC_src` is 000 in every state not listed above.

## Timing
- Reset values:
  - State: FETCH.
  - `PC_src`=000.
  - `PC_write`, `EPC_write`, `exc_req`, `exec_start`: 0.
  - `exc_cause`=00.
  - Counter: 0.
- First `PC_write` is in the first cycle after `reset` deasserts.
- Outputs are Moore, decoded from registered state. The exception is BRANCH `PC_write`, which is combinational on `zero`/`gt` in that cycle.
- Latency from FETCH to the next FETCH:
  - Branch, jump, jr, rte: 3 cycles.
  - EXEC: 3 + N cycles, where N is cycles until `exec_done`. `exec_done` in the first EXEC cycle gives 3.
  - Exception from EXEC: at least 4 cycles after the event.
- `reset` asserted mid-sequence: outputs clear immediately and asynchronously, with no partial PC/EPC write.
- `exc_ready` seen outside EXC_WAIT is ignored.

## Configuration
- `PC_SEQ_EXC_EN`:
- Defined: exception states, cause register, timeout counter and RTE are present, as described above.
- Undefined:
  - Invalid opcodes and RTE go to FETCH.
  - `overflow` and `div_zero` are ignored.
  - `PC_src` never takes 011 or 100.
  - `EPC_write`, `exc_req` and `exc_cause` are tied to 0.

## Test plan
- Reset release, then R-type add with `exec_done` in the 2nd EXEC cycle: `PC_write` in cycles 1 and 5 only, `PC_src`=000 throughout.
- beq with `zero`=1 and bne with `zero`=1: beq gives `PC_write`=1 with `PC_src`=001 in the BRANCH cycle; bne gives `PC_write`=0.
- j 0x02, then jr, then rte: `PC_src` is 010, then 000, then 100, each with a single `PC_write` in the 3rd cycle.
- Opcode 0x3F: `EPC_write` in the cycle after DECODE; `exc_req`=1 with `exc_cause`=00; `exc_ready` after 3 cycles gives `PC_src`=011 with `PC_write`=1, then FETCH.
- `overflow`, `div_zero` and `exec_done` all in the same EXEC cycle: `exc_cause`=01. With `exc_ready` never asserted, EXC_LOAD is reached after 15 cycles in EXC_WAIT.
- `reset` asserted during EXC_WAIT: `exc_req` drops asynchronously, and the next post-reset cycle is FETCH with `PC_write`=1.
